// File: rtl/shift_right_seq_if.sv
// Request/result bundle for the sequential right shifter.
// master = requester/consumer side, slave = shifter side.
interface shift_right_seq_if;
    logic        start;
    logic        ready;
    logic [31:0] rs1;
    logic [4:0]  imm;
    logic        arith;
    logic        flush;
    logic [31:0] rd_right;
    logic        done;
    logic        ack;

    modport master (
        output start, rs1, imm, arith, flush, ack,
        input  ready, rd_right, done
    );

    modport slave (
        input  start, rs1, imm, arith, flush, ack,
        output ready, rd_right, done
    );
endinterface

// File: rtl/shift_right_seq.sv
// Purpose: 32-bit logical/arithmetic right shift, one binary-weighted stage (16,8,4,2,1) per cycle.
// Latency: done on the 6th edge counting the accepting edge (1st with EARLY_DONE=1 and imm==0).
// Backpressure: result held in DONE until ack; ready only in IDLE, so no accept on the ack edge.
module shift_right_seq #(
    parameter bit EARLY_DONE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    shift_right_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] data_q;
    logic [4:0]  shamt_q;
    logic        mode_q;
    logic [2:0]  k_q;

    logic        accept;
    logic        bypass;
    logic [4:0]  stage_w;
    logic        stage_en;
    logic        fill;
    logic signed [32:0] ext;
    logic signed [32:0] ext_sh;
    logic [31:0] stage_out;

    assign accept = (state_q == IDLE) && bus.start && !bus.flush;
    assign bypass = EARLY_DONE && (bus.imm == 5'd0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = bypass ? DONE : SHIFT;
            SHIFT:   if (k_q == 3'd4) state_d = DONE;
            DONE:    if (bus.ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.flush) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        stage_w  = 5'd0;
        stage_en = 1'b0;
        case (k_q)
            3'd0: begin stage_w = 5'd16; stage_en = shamt_q[4]; end
            3'd1: begin stage_w = 5'd8;  stage_en = shamt_q[3]; end
            3'd2: begin stage_w = 5'd4;  stage_en = shamt_q[2]; end
            3'd3: begin stage_w = 5'd2;  stage_en = shamt_q[1]; end
            3'd4: begin stage_w = 5'd1;  stage_en = shamt_q[0]; end
            default: begin stage_w = 5'd0; stage_en = 1'b0; end
        endcase
    end

    // Arithmetic stages keep bit 31 equal to the operand's original sign,
    // so the current bit 31 is a valid fill source for every stage.
    assign fill      = mode_q & data_q[31];
    assign ext       = {fill, data_q};
    assign ext_sh    = ext >>> stage_w;
    assign stage_out = stage_en ? ext_sh[31:0] : data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= 32'h0;
            shamt_q <= 5'd0;
            mode_q  <= 1'b0;
            k_q     <= 3'd0;
        end else if (accept) begin
            data_q  <= bus.rs1;
            shamt_q <= bus.imm;
            mode_q  <= bus.arith;
            k_q     <= 3'd0;
        end else if ((state_q == SHIFT) && !bus.flush) begin
            data_q  <= stage_out;
            k_q     <= k_q + 3'd1;
        end
    end

    assign bus.ready    = (state_q == IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.rd_right = data_q;

endmodule
